// File: rtl/sky130_sram_arb_pkg.sv
// Shared types and default widths for the sky130 1rw port arbiter.
package sky130_sram_arb_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = 4;

    typedef enum logic {INIT, RUN} state_e;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    // rd marks an issue that produces a response; id is the requester index.
    typedef struct packed {
        logic rd;
        logic id;
    } tag_t;

endpackage

// File: rtl/sky130_sram_rr_arb2.sv
// Two-way round-robin picker: ready is combinational from valids and the priority flop.
module sky130_sram_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] ready,
    output logic       grant_id,
    output logic       grant_vld
);

    logic prio_q, prio_d;

    always_comb begin
        ready  = 2'b00;
        prio_d = prio_q;
        if (en) begin
            ready[0] = valid[0] & (~valid[1] | ~prio_q);
            ready[1] = valid[1] & (~valid[0] |  prio_q);
        end
        grant_vld = |ready;
        grant_id  = ready[1];
        // The loser of this grant (or the idle side) gets priority next.
        if (grant_vld) prio_d = ~grant_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end

endmodule

// File: rtl/sky130_sram_arbiter_1rw.sv
// Two-requester arbiter/sequencer for port 0 of the sky130 1rw1r 32x1024 macro.
// SRAM_ARB_INIT_EN: when defined, zero-fills the array after reset before accepting requests.
module sky130_sram_arbiter_1rw #(
    parameter int ADDR_WIDTH = sky130_sram_arb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sky130_sram_arb_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS = sky130_sram_arb_pkg::NUM_WMASKS
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [NUM_WMASKS-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [NUM_WMASKS-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_csb0,
    output logic                  mem_web0,
    output logic [NUM_WMASKS-1:0] mem_wmask0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    input  logic [DATA_WIDTH-1:0] mem_dout0,
    output logic                  init_done
);

    import sky130_sram_arb_pkg::*;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } lreq_t;

    logic                  init_wr;
    logic [ADDR_WIDTH-1:0] init_addr;

`ifdef SRAM_ARB_INIT_EN
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == INIT) begin
            init_addr_d = init_addr_q + 1'b1;
            if (&init_addr_q) state_d = RUN;
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q     <= INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    assign init_wr   = (state_q == INIT);
    assign init_addr = init_addr_q;
    assign init_done = (state_q == RUN);
`else
    assign init_wr   = 1'b0;
    assign init_addr = '0;
    assign init_done = 1'b1;
`endif

    logic [1:0] req_valid, arb_ready;
    logic       grant_id, grant_vld;

    assign req_valid = {req1_valid, req0_valid};

    // Readiness is forced low while in reset or while the fill sequence owns the port.
    sky130_sram_rr_arb2 u_arb (
        .clk       (clk0),
        .rst       (rst0),
        .en        (~init_wr & ~rst0),
        .valid     (req_valid),
        .ready     (arb_ready),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    assign req0_ready = arb_ready[0];
    assign req1_ready = arb_ready[1];

    lreq_t req0_s, req1_s, win;
    assign req0_s = '{we: req0_we, wmask: req0_wmask, addr: req0_addr, wdata: req0_wdata};
    assign req1_s = '{we: req1_we, wmask: req1_wmask, addr: req1_addr, wdata: req1_wdata};
    assign win    = grant_id ? req1_s : req0_s;

    logic                  csb_q, csb_d, web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    tag_t                  tag_d, tag0_q, tag1_q;

    always_comb begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        tag_d   = '0;
        if (init_wr) begin
            csb_d   = 1'b0;
            web_d   = 1'b0;
            wmask_d = '1;
            addr_d  = init_addr;
            din_d   = '0;
        end else if (grant_vld) begin
            csb_d   = 1'b0;
            web_d   = ~win.we;
            wmask_d = win.wmask;
            addr_d  = win.addr;
            din_d   = win.wdata;
            tag_d   = '{rd: ~win.we, id: grant_id};
        end
    end

    // The macro registers its inputs one edge after issue and its dout is
    // stable by the following edge, so the tag meets the data two stages later.
    logic [1:0]                 rsp_vld_q, rsp_vld_d;
    logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rsp_vld_d[i] = tag1_q.rd & (tag1_q.id == 1'(i));
            rdata_d[i]   = rsp_vld_d[i] ? mem_dout0 : rdata_q[i];
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            wmask_q   <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            tag0_q    <= '0;
            tag1_q    <= '0;
            rsp_vld_q <= '0;
            rdata_q   <= '0;
        end else begin
            csb_q     <= csb_d;
            web_q     <= web_d;
            wmask_q   <= wmask_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            tag0_q    <= tag_d;
            tag1_q    <= tag0_q;
            rsp_vld_q <= rsp_vld_d;
            rdata_q   <= rdata_d;
        end
    end

    assign mem_csb0   = csb_q;
    assign mem_web0   = web_q;
    assign mem_wmask0 = wmask_q;
    assign mem_addr0  = addr_q;
    assign mem_din0   = din_q;
    assign rsp0_valid = rsp_vld_q[0];
    assign rsp1_valid = rsp_vld_q[1];
    assign rsp0_rdata = rdata_q[0];
    assign rsp1_rdata = rdata_q[1];

endmodule

// File: doc/sky130_sram_arbiter_1rw.md
# sky130_sram_arbiter_1rw

Two-requester round-robin arbiter and sequencer for the RW port (port 0) of the `sky130_sram_4kbyte_1rw1r_32x1024_8` macro.
- Accepts independent valid/ready read/write requests, issues at most one macro access per cycle and drives registered macro controls.
- Returns read data to the originating requester with fixed latency.
- Optionally zero-fills the array after reset.
- Sits between two bus masters and the macro; port 1 of the macro is outside this block.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word address width (1024 words).
- `DATA_WIDTH`, 32: word width.
- `NUM_WMASKS`, 4: byte-lane write-mask width.

Ports:
- `clk0`  in  1  clock, shared with macro `clk0`; one clock domain.
- `rst0`  in  1  reset, asynchronous, active-high.
- `reqN_valid`  in  1  request valid, N=0,1.
- `reqN_ready`  out  1  request accepted when valid&ready at posedge.
- `reqN_we`  in  1  1=write, 0=read.
- `reqN_wmask`  in  NUM_WMASKS  byte enables, writes only.
- `reqN_addr`  in  ADDR_WIDTH  word address.
- `reqN_wdata`  in  DATA_WIDTH  write data.
- `rspN_valid`  out  1  one-cycle read-response strobe.
- `rspN_rdata`  out  DATA_WIDTH  read data, valid with strobe.
- `mem_csb0`  out  1  macro chip select, active low.
- `mem_web0`  out  1  macro write enable, active low.
- `mem_wmask0`  out  NUM_WMASKS  macro write mask.
- `mem_addr0`  out  ADDR_WIDTH  macro address.
- `mem_din0`  out  DATA_WIDTH  macro write data.
- `mem_dout0`  in  DATA_WIDTH  macro read data.
- `init_done`  out  1  high once requests may be accepted.

## Operation
- States: `INIT` and `RUN`. Reset enters `INIT` when `SRAM_ARB_INIT_EN` is defined, otherwise `RUN`.
- Readiness: `reqN_ready` is low in `INIT`. In `RUN`, `reqN_ready` is combinational from the valids and the priority pointer `prio`. It never depends on `reqN_ready`.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: requester `prio` is granted.
  - After any grant, `prio` becomes the non-granted index.
  - Reset value of `prio` is 0.
- Issue: on handshake at posedge T, flops load `mem_csb0=0`, `mem_web0=~we`, and `mem_wmask0`/`mem_addr0`/`mem_din0` from the winner.
- Idle: with no handshake, `mem_csb0=1` and `mem_web0=1`. Addr/din/wmask hold their last value.
- Tag pipeline: each issue pushes {valid-read, requester id} into a 2-deep pipeline. Writes push valid-read=0.
- Read return: a read accepted at T has `mem_dout0` sampled at posedge T+2 into `rspN_rdata`, with `rspN_valid`=1 for the single cycle after T+2.
  - There is no response backpressure. Requesters must always accept responses.
- Writes: no response. A write at T is visible to a read accepted at T+1 or later, because the macro writes on the negedge of T+1.
- Back-to-back: full throughput, one access per cycle, reads and writes interleaved arbitrarily.
- Reset values: `mem_csb0=1`, `mem_web0=1`, `mem_wmask0=0`, `mem_addr0=0`, `mem_din0=0`, `reqN_ready=0` during reset, `rspN_valid=0`, `rspN_rdata=0`, tags cleared, `prio=0`.
- Reset mid-operation: in-flight reads are dropped with no response. `INIT` restarts from address 0.

## Timing
- Accept to read response: 2 cycles. `rspN_valid` is high in cycle T+2.
- Accept to macro input registered: 1 cycle. Macro samples at posedge T+1.
- Both requesters continuously valid: grants alternate 0,1,0,1…, starting with 0 after reset.
- Response ordering per requester equals acceptance order.

## Configuration
- `SRAM_ARB_INIT_EN` defined:
  - After reset, `INIT` issues writes of 0 with `wmask0=4'hF` to addresses 0..1023, one per cycle, starting the cycle after reset release. An `ADDR_WIDTH`-bit counter wraps to 0.
  - `INIT`→`RUN` after address 1023 issues. `init_done` rises in the same cycle as `RUN`. Total 1024 cycles.
  - Requests are held off (ready=0) throughout. Reset value of `init_done` is 0.
- `SRAM_ARB_INIT_EN` undefined: no counter, no `INIT` state, and `init_done` reads 1 from reset onward.

## Structure
- Package `sky130_sram_arb_pkg` holds:
  - `ADDR_WIDTH`/`DATA_WIDTH`/`NUM_WMASKS` defaults.
  - State enum {INIT, RUN}.
  - Packed request struct {we, wmask, addr, wdata}.
  - Tag struct {rd, id}.
- One sub-module: `sky130_sram_rr_arb2`, a two-way round-robin picker with valids in, `prio` register, grant/ready out.

## Test plan
- Single read: req0 reads addr 0x005 after writing 32'hDEADBEEF there → `rsp0_valid` 2 cycles after accept, `rsp0_rdata`=32'hDEADBEEF; `rsp1_valid` stays 0.
- Byte mask: write 32'h11223344 mask 4'hF, then 32'hAABBCCDD mask 4'b0101 to 0x3FF → readback 32'h11BB33DD.
- Contention: both valid 8 cycles with reads of distinct addrs → grants 0,1,0,1…; each `rspN_valid` pulses 4 times with correct data and order.
- Read-after-write: req1 writes 0x010=32'hCAFEF00D at T, req0 reads 0x010 at T+1 → `rsp0_rdata`=32'hCAFEF00D at T+3.
- Init (`SRAM_ARB_INIT_EN`): pre-load addr 0x200=32'hFFFFFFFF, reset → `init_done` low for 1024 cycles, ready 0, then read of 0x200 returns 0.
- Mid-flight reset: assert `rst0` the cycle after a read accept → no `rsp0_valid`, all outputs at reset values during reset, `prio` returns to 0.
